// File: rtl/uart_ascii_pkg.sv
// rtl/uart_ascii_pkg.sv - shared state encoding and ASCII constants (PARITY state only with UART_ASCII_PARITY_EN)
package uart_ascii_pkg;

  localparam logic [6:0] ASCII_BS  = 7'h08;
  localparam logic [6:0] ASCII_LF  = 7'h0A;
  localparam logic [6:0] ASCII_CR  = 7'h0D;
  localparam logic [6:0] ASCII_DEL = 7'h7F;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_ASCII_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - synchronised 8N1 receiver emitting a one-cycle byte/error strobe (even parity with UART_ASCII_PARITY_EN)
module uart_rx
  import uart_ascii_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int FW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic                   rx_prev;
  logic [FW-1:0]          fill;
  logic                   armed;
  rx_state_t              state;
  logic [CW-1:0]          cnt;
  logic [2:0]             idx;
  logic [7:0]             shreg;
  logic                   tick;
  logic                   stop_ok;

  assign rx_s = sync[SYNC_STAGES-1];
  assign tick = (cnt == '0);

`ifdef UART_ASCII_PARITY_EN
  logic parity_bad;
  assign stop_ok = rx_s && !parity_bad;
`else
  assign stop_ok = rx_s;
`endif

  assign byte_valid = (state == STOP) && tick && stop_ok;
  assign frame_err  = (state == STOP) && tick && !stop_ok;
  assign byte_data  = shreg;

  // Edge detection stays disarmed until a genuine high has crossed the synchroniser,
  // so a line that is low when reset releases never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync    <= '1;
      rx_prev <= 1'b1;
      fill    <= '0;
      armed   <= 1'b0;
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
`ifdef UART_ASCII_PARITY_EN
      parity_bad <= 1'b0;
`endif
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], rx};
      rx_prev <= rx_s;
      if (fill != FW'(SYNC_STAGES)) fill <= fill + FW'(1);
      else if (rx_s) armed <= 1'b1;
      if (!tick) cnt <= cnt - CW'(1);
      case (state)
        IDLE: begin
          if (armed && rx_prev && !rx_s) begin
            state <= START;
            cnt   <= HALF_LOAD;
          end
        end
        START: begin
          if (tick) begin
            if (!rx_s) begin
              state <= DATA;
              cnt   <= BIT_LOAD;
              idx   <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shreg[idx] <= rx_s;
            cnt        <= BIT_LOAD;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_ASCII_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_ASCII_PARITY_EN
        PARITY: begin
          if (tick) begin
            parity_bad <= ^{shreg, rx_s};
            cnt        <= BIT_LOAD;
            state      <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) state <= stop_ok ? IDLE : WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_ascii_source.sv
// rtl/uart_ascii_source.sv - UART byte to terminal character mapping with CR/LF folding (parity via UART_ASCII_PARITY_EN)
module uart_ascii_source
  import uart_ascii_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       add_char,
  output logic [6:0] char_value,
  output logic       frame_error
);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;
  logic       cr_flag;
  logic       emit;
  logic [6:0] mapped;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  always_comb begin
    emit   = 1'b1;
    mapped = byte_data[6:0];
    if (byte_data[7]) begin
      emit = 1'b0;
    end else if (byte_data[6:0] == ASCII_CR) begin
      mapped = ASCII_LF;
    end else if (byte_data[6:0] == ASCII_DEL) begin
      mapped = ASCII_BS;
    end else if (byte_data[6:0] == ASCII_LF && cr_flag) begin
      emit = 1'b0;
    end
  end

  // The CR flag remembers only the immediately preceding accepted byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      add_char    <= 1'b0;
      frame_error <= 1'b0;
      char_value  <= 7'h00;
      cr_flag     <= 1'b0;
    end else begin
      add_char    <= byte_valid && emit;
      frame_error <= frame_err;
      if (byte_valid) begin
        cr_flag <= (byte_data == {1'b0, ASCII_CR});
        if (emit) char_value <= mapped;
      end else if (frame_err) begin
        cr_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_ascii_source.sv
// tb/tb_uart_ascii_source.sv - randomized self-checking bench against a frame-level reference model (UART_ASCII_PARITY_EN aware)
module tb_uart_ascii_source;

  localparam int CPB  = 16;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       add_char;
  logic [6:0] char_value;
  logic       frame_error;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [6:0] got_q[$];
  int         got_cyc[$];
  int         fe_cnt = 0;
  logic [6:0] exp_q[$];
  int         exp_fe = 0;
  bit         model_cr = 0;
  int         stop_cyc = 0;
  logic       prev_add = 1'b0;

  uart_ascii_source #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .add_char   (add_char),
    .char_value (char_value),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (add_char) begin
        got_q.push_back(char_value);
        got_cyc.push_back(cyc);
        check("strobe_one_cycle", prev_add, 1'b0);
        check("strobe_exclusive", frame_error, 1'b0);
      end
      if (frame_error) fe_cnt++;
    end
    prev_add = add_char;
  end

  // Reference: what a terminal should see for one correctly framed byte.
  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h80) begin
    end else if (b == 8'h0D) exp_q.push_back(7'h0A);
    else if (b == 8'h7F) exp_q.push_back(7'h08);
    else if (b == 8'h0A && model_cr) begin
    end else exp_q.push_back(b[6:0]);
    model_cr = (b == 8'h0D);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                            input int low_after);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_ASCII_PARITY_EN
    rx = (^b) ^ par_flip;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop_bit;
    stop_cyc = cyc;
    repeat (CPB) @(negedge clk);
    if (!stop_bit) begin
      rx = 1'b0;
      repeat (low_after * CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic settle_and_compare();
    repeat (2 * CPB) @(negedge clk);
    check("strobe_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check("char_value", got_q[i], exp_q[i]);
      check("strobe_in_stop_bit",
            (got_cyc[i] - stop_cyc >= CPB / 4) && (got_cyc[i] - stop_cyc <= CPB / 2 + SYNC + 4), 1'b1);
    end
    check("frame_error_count", fe_cnt, exp_fe);
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    fe_cnt = 0;
    exp_fe = 0;
  endtask

  task automatic run_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                           input int low_after);
    send_frame(b, stop_bit, par_flip, low_after);
`ifdef UART_ASCII_PARITY_EN
    if (stop_bit && !par_flip) model_byte(b);
`else
    if (stop_bit) model_byte(b);
`endif
    else begin
      model_cr = 0;
      exp_fe++;
    end
    settle_and_compare();
  endtask

  initial begin
    logic [7:0] b;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_add_char", add_char, 1'b0);
    check("rst_frame_error", frame_error, 1'b0);
    check("rst_char_value", char_value, 7'h00);
    reset = 1'b0;
    repeat (4 * CPB) @(negedge clk);

    run_frame(8'h41, 1'b1, 1'b0, 0);
    run_frame(8'h0D, 1'b1, 1'b0, 0);
    run_frame(8'h0A, 1'b1, 1'b0, 0);
    run_frame(8'h0A, 1'b1, 1'b0, 0);
    run_frame(8'h7F, 1'b1, 1'b0, 0);
    run_frame(8'hC1, 1'b1, 1'b0, 0);
    run_frame(8'h55, 1'b0, 1'b0, 20);
    run_frame(8'h42, 1'b1, 1'b0, 0);

    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    settle_and_compare();
    run_frame(8'h41, 1'b1, 1'b0, 0);

    b = 8'h41;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == 4) reset = 1'b1;
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    check("midframe_rst_char_value", char_value, 7'h00);
    reset = 1'b0;
    model_cr = 0;
    settle_and_compare();
    run_frame(8'h43, 1'b1, 1'b0, 0);

`ifdef UART_ASCII_PARITY_EN
    run_frame(8'h41, 1'b1, 1'b1, 0);
    run_frame(8'h42, 1'b1, 1'b0, 0);
`endif

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 7))
        0:       b = 8'h0D;
        1:       b = 8'h0A;
        2:       b = 8'h7F;
        3:       b = 8'h80 | 8'($urandom_range(0, 127));
        default: b = 8'($urandom_range(0, 127));
      endcase
      run_frame(b, ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0),
                $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
